mpu_clock_ctrl: RTL and testbench
=================================

// Module: mpu_clock_ctrl
// PURPOSE
// - 6502 PHI0 clock generator/sequencer between board debouncers and the MPU socket.
// - Generalises the fixed divider with four modes (STOP/RUN/STEP/BURST) and a parametrised divide.
// - Adds an N-cycle burst per button press, a clocked reset sequence and clk-domain phase strobes.
// - Strobes let bus logic sample addr_bus/drive data_bus on known edges.
// PARAMETERS
// - HALF_DIV   default 25_000_000  clk cycles per PHI0 half period (>=2); full cycle = 2*HALF_DIV
// - CNT_W      default 16          width of burst_len and cycle_cnt
// - RST_CYCLES default 8           full PHI0 cycles with mpu_rst_n low in the reset sequence (>=2)
// - AUTO_RST   default 1           1: run the reset sequence automatically after rst_n release
// PORTS
// - clk          in   1      system clock (50 MHz)
// - rst_n        in   1      asynchronous active-low reset
// - mode         in   2      00 STOP, 01 RUN, 10 STEP, 11 BURST; sampled every clk
// - step_press   in   1      1-clk pulse from debouncer; starts a STEP/BURST
// - burst_len    in   CNT_W  cycles per BURST press; sampled on the accepted press
// - rst_req      in   1      1-clk pulse; starts the MPU reset sequence
// - mpu_clk      out  1      PHI0 to the 6502; registered, idles high
// - mpu_rst_n    out  1      6502 RESB; registered
// - phi_fall     out  1      1-clk strobe, same edge mpu_clk goes low
// - phi_rise     out  1      1-clk strobe, same edge mpu_clk goes high (cycle complete)
// - busy         out  1      high while a step, burst or reset sequence is in progress
// - cycle_cnt    out  CNT_W  completed PHI0 cycles since last mpu_rst_n release; wraps
// BEHAVIOUR
// - Reset (rst_n low): mpu_clk=1, mpu_rst_n=0, strobes=0, busy=AUTO_RST, cycle_cnt=0,
//   state=RESET when AUTO_RST else IDLE.
// - A PHI0 cycle is fall then rise. Each phase lasts exactly HALF_DIV clks.
//   Phases are never truncated; all mode and state changes act only at a rise (cycle boundary).
// - States: IDLE, RUN, BURST, RESET.
// - IDLE: mpu_clk held 1.
//   - mode=RUN -> RUN.
//   - step_press with mode=STEP -> BURST with remaining=1.
//   - step_press with mode=BURST and burst_len!=0 -> BURST with remaining=burst_len.
//   - burst_len=0 is a no-op. step_press in STOP/RUN is ignored.
// - Start latency: mpu_clk falls on the clk edge after the accepting edge (phi_fall the same edge).
// - RUN: free-running cycles. At each rise, mode!=RUN -> IDLE; clock parks high.
// - BURST: remaining decrements at each rise and reaches IDLE at the rise where remaining hits 0.
//   - Presses while busy are ignored (no queueing).
//   - A mode change mid-burst does not abort it.
// - rst_req (any state, any phase): latched. Taken at the next rise (immediately if IDLE).
//   - RESET: mpu_rst_n=0 and RST_CYCLES free-running cycles regardless of mode.
//   - mpu_rst_n goes 1 at the final rise, cycle_cnt clears to 0, state -> IDLE.
//   - rst_req during RESET restarts the RST_CYCLES count at the next rise.
// - busy=1 in RESET and BURST, and in RUN; 0 only in IDLE.
// - cycle_cnt increments at every rise outside RESET and wraps at 2^CNT_W-1 -> 0.
// - Simultaneous step_press and rst_req: rst_req wins; the press is dropped.
// - Simultaneous rst_req and a rise: the reset sequence starts on that rise.
// - rst_n assertion mid-cycle: immediate async return to reset values; no completion guarantee.
// STRUCTURE
// - Package mpu_clk_pkg: mode encodings (MODE_STOP/RUN/STEP/BURST) and the state typedef/localparams.
// - Sub-module mpu_phase_gen: HALF_DIV divider plus the mpu_clk flop.
//   - Interface: cycle_req level in; phi_fall/phi_rise strobes out.
//   - Idles high while cycle_req=0 at a rise.
// - Top holds the FSM, remaining and RESET counters, the rst_req latch and cycle_cnt.
// TESTING (HALF_DIV=4, RST_CYCLES=3, AUTO_RST=1, CNT_W=8)
// - Release rst_n -> 3 cycles of 8 clks with mpu_rst_n=0; mpu_rst_n=1 at 3rd rise; busy=0; cycle_cnt=0.
// - mode=STEP, step_press -> mpu_clk low 4 clks, high; exactly one phi_fall/phi_rise; cycle_cnt=1.
// - mode=BURST, burst_len=5, press, extra press mid-burst -> exactly 5 cycles (40 clks); cycle_cnt+=5.
// - burst_len=0 press -> no clock activity. mode RUN then STOP mid-low-phase -> cycle completes, parks high.
// - rst_req during burst cycle 2 (low phase) -> cycle completes; reset sequence follows; burst abandoned.
// - step_press and rst_req same clk -> reset sequence only. cycle_cnt=255 then +1 cycle -> 0.

Source files
------------

// File: rtl/mpu_clk_pkg.sv
// Shared types for the 6502 PHI0 clock controller: mode encodings, the
// controller state type and a small counter-width helper.
package mpu_clk_pkg;

  localparam int unsigned MODE_W = 2;

  // Front-panel mode selector encodings
  typedef enum logic [MODE_W-1:0] {
    MODE_STOP  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_RESET = 2'b11
  } state_e;

  // Bits needed to hold the values 0..n-1 (at least one bit)
  function automatic int unsigned bits_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mpu_phase_gen.sv
// PHI0 phase generator: divides clk by HALF_DIV per half period and drives
// the registered mpu_clk. A cycle is a low phase followed by a high phase;
// a new cycle starts only once the high phase has fully elapsed and
// cycle_req is high, otherwise mpu_clk parks high.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   cycle_req    level: keep producing PHI0 cycles
//   mpu_clk      registered PHI0 (idles high)
//   phi_fall     1-clk strobe on the edge mpu_clk goes low
//   phi_rise     1-clk strobe on the edge mpu_clk goes high
//   rise_c       combinational: the coming clk edge is a rise
module mpu_phase_gen
  import mpu_clk_pkg::*;
#(
  parameter int unsigned HALF_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cycle_req,
  output logic mpu_clk,
  output logic phi_fall,
  output logic phi_rise,
  output logic rise_c
);

  localparam int unsigned      DIV_W = bits_for(HALF_DIV);
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;
  logic             phase_done;

  // Phase counter and clock edge selection; counter saturates at LAST while parked
  always_comb begin
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    fall_d     = 1'b0;
    rise_d     = 1'b0;
    phase_done = (cnt_q == LAST);
    if (!clk_q) begin
      if (phase_done) begin
        clk_d  = 1'b1;
        rise_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      if (phase_done) begin
        if (cycle_req) begin
          clk_d  = 1'b0;
          fall_d = 1'b1;
          cnt_d  = '0;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Reset leaves the generator parked high with the high phase complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LAST;
      clk_q  <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign mpu_clk  = clk_q;
  assign phi_fall = fall_q;
  assign phi_rise = rise_q;
  assign rise_c   = rise_d;

endmodule

// File: rtl/mpu_clock_ctrl.sv
// 6502 PHI0 clock generator/sequencer. Offers STOP/RUN/STEP/BURST modes,
// an N-cycle burst per button press, a clocked MPU reset sequence and
// clk-domain phase strobes. All state changes take effect on a PHI0 rise
// (cycle boundary) except leaving IDLE, which happens immediately.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   mode         00 STOP, 01 RUN, 10 STEP, 11 BURST
//   step_press   1-clk press pulse (STEP/BURST start)
//   burst_len    cycles per BURST press, sampled on the accepted press
//   rst_req      1-clk pulse requesting the MPU reset sequence
//   mpu_clk      PHI0 to the MPU (registered, idles high)
//   mpu_rst_n    MPU RESB (registered)
//   phi_fall     strobe on the edge PHI0 goes low
//   phi_rise     strobe on the edge PHI0 goes high
//   busy         high whenever not IDLE
//   cycle_cnt    completed PHI0 cycles since the last reset release
module mpu_clock_ctrl
  import mpu_clk_pkg::*;
#(
  parameter int unsigned HALF_DIV   = 25_000_000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned AUTO_RST   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step_press,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             rst_req,
  output logic             mpu_clk,
  output logic             mpu_rst_n,
  output logic             phi_fall,
  output logic             phi_rise,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned      RC_W      = bits_for(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LOAD   = RC_W'(RST_CYCLES);
  localparam state_e           RST_STATE = (AUTO_RST != 0) ? ST_RESET : ST_IDLE;
  localparam logic             RST_BUSY  = (AUTO_RST != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             rst_pend_q, rst_pend_d;
  logic             mpu_rst_n_q, mpu_rst_n_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  mode_e            mode_in;
  logic             pend_any;
  logic             rise_c;
  logic             cycle_req;

  assign mode_in   = mode_e'(mode);
  assign pend_any  = rst_pend_q | rst_req;
  assign cycle_req = (state_q != ST_IDLE);

  mpu_phase_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .cycle_req (cycle_req),
    .mpu_clk   (mpu_clk),
    .phi_fall  (phi_fall),
    .phi_rise  (phi_rise),
    .rise_c    (rise_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      rem_q       <= '0;
      rc_q        <= RC_LOAD;
      rst_pend_q  <= 1'b0;
      mpu_rst_n_q <= 1'b0;
      busy_q      <= RST_BUSY;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      rc_q        <= rc_d;
      rst_pend_q  <= rst_pend_d;
      mpu_rst_n_q <= mpu_rst_n_d;
      busy_q      <= busy_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next state: a pending reset request outranks everything else and is
  // consumed when it is taken (at once from IDLE, otherwise at a rise)
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    rc_d       = rc_q;
    rst_pend_d = pend_any;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_any) begin
          state_d    = ST_RESET;
          rc_d       = RC_LOAD;
          rst_pend_d = 1'b0;
        end else if (mode_in == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (step_press && mode_in == MODE_STEP) begin
          state_d = ST_BURST;
          rem_d   = CNT_W'(1);
        end else if (step_press && mode_in == MODE_BURST && burst_len != '0) begin
          state_d = ST_BURST;
          rem_d   = burst_len;
        end
      end
      ST_RUN, ST_BURST, ST_RESET: begin
        if (rise_c) begin
          if (pend_any) begin
            state_d    = ST_RESET;
            rc_d       = RC_LOAD;
            rst_pend_d = 1'b0;
          end else if (state_q == ST_RUN) begin
            if (mode_in != MODE_RUN) state_d = ST_IDLE;
          end else if (state_q == ST_BURST) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = ST_IDLE;
          end else begin
            rc_d = rc_q - RC_W'(1);
            if (rc_q == RC_W'(1)) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: RESB follows reset-sequence entry/exit, cycle
  // count advances on rises outside RESET and clears on release
  always_comb begin
    mpu_rst_n_d = mpu_rst_n_q;
    busy_d      = (state_d != ST_IDLE);
    cycle_cnt_d = cycle_cnt_q;
    if (state_d == ST_RESET) begin
      mpu_rst_n_d = 1'b0;
    end else if (state_q == ST_RESET) begin
      mpu_rst_n_d = 1'b1;
    end
    if (rise_c) begin
      if (state_q == ST_RESET) begin
        if (state_d == ST_IDLE) cycle_cnt_d = '0;
      end else begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mpu_rst_n = mpu_rst_n_q;
  assign busy      = busy_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mpu_clock_ctrl.sv
// Scoreboard bench for mpu_clock_ctrl. Each command predicts the list of
// PHI0 rises it must produce (edge index, RESB level, cycle count); a
// monitor pops one prediction per phi_rise and compares.
module tb_mpu_clock_ctrl;
  import mpu_clk_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned RC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          step_press = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          rst_req = 1'b0;
  logic          mpu_clk, mpu_rst_n, phi_fall, phi_rise, busy;
  logic [CW-1:0] cycle_cnt;

  mpu_clock_ctrl #(
    .HALF_DIV   (H),
    .CNT_W      (CW),
    .RST_CYCLES (RC),
    .AUTO_RST   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .step_press (step_press),
    .burst_len  (burst_len),
    .rst_req    (rst_req),
    .mpu_clk    (mpu_clk),
    .mpu_rst_n  (mpu_rst_n),
    .phi_fall   (phi_fall),
    .phi_rise   (phi_rise),
    .busy       (busy),
    .cycle_cnt  (cycle_cnt)
  );

  typedef struct {
    int unsigned   rise_at;
    logic          rstn;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_mon;
  int unsigned   cyc = 0;
  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  int unsigned   n_falls = 0;
  int unsigned   last_fall = 0;
  logic          prev_clk = 1'b1;
  logic [CW-1:0] m_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ordinary cycles: each completed rise bumps the count
  task automatic push_cycles(input int unsigned first, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      m_cnt = m_cnt + 1'b1;
      sb.push_back('{first + 2*H*k, 1'b1, m_cnt});
    end
  endtask

  // Reset sequence: RESB low, count frozen, release and clear on the last rise
  task automatic push_reset(input int unsigned first);
    for (int unsigned j = 0; j < RC; j++) begin
      if (j == RC - 1) sb.push_back('{first + 2*H*j, 1'b1, CW'(0)});
      else             sb.push_back('{first + 2*H*j, 1'b0, m_cnt});
    end
    m_cnt = '0;
  endtask

  // Monitor: strobe/edge coherence and scoreboard pop on every rise
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (mpu_clk !== prev_clk || phi_fall || phi_rise) begin
        check("fall_strobe", 32'(phi_fall), 32'(prev_clk === 1'b1 && mpu_clk === 1'b0));
        check("rise_strobe", 32'(phi_rise), 32'(prev_clk === 1'b0 && mpu_clk === 1'b1));
      end
      if (phi_fall) begin
        n_falls++;
        last_fall = cyc;
      end
      if (phi_rise) begin
        check("low_len", cyc - last_fall, H);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rise: rise at cyc %0d expected none", cyc);
        end else begin
          e_mon = sb.pop_front();
          check("rise_edge", cyc, e_mon.rise_at);
          check("rise_rstn", 32'(mpu_rst_n), 32'(e_mon.rstn));
          check("rise_cnt", 32'(cycle_cnt), 32'(e_mon.cnt));
        end
      end
    end
    prev_clk = mpu_clk;
  end

  // Wait for all predicted rises, let the high phase finish, check idle
  task automatic drain();
    int unsigned b = 0;
    while (sb.size() != 0 && b < 4000) begin
      tick();
      b++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d rises outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (H + 2) tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_clk", 32'(mpu_clk), 1);
    check("idle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic do_step();
    int unsigned a;
    mode = MODE_STEP; step_press = 1'b1; a = cyc + 1;
    push_cycles(a + 1 + H, 1);
    tick();
    step_press = 1'b0;
    drain();
  endtask

  task automatic do_burst(input int unsigned len, input bit extra, input bit mid_mode);
    int unsigned a, d, f0;
    f0 = n_falls;
    mode = MODE_BURST; burst_len = CW'(len); step_press = 1'b1; a = cyc + 1;
    if (len != 0) push_cycles(a + 1 + H, len);
    tick();
    step_press = 1'b0;
    if (len != 0 && extra) begin
      d = $urandom_range(2*H*len - H, 0);
      repeat (d) tick();
      step_press = 1'b1;
      burst_len = CW'($urandom_range(9, 1));
      if (mid_mode) mode = ($urandom_range(1, 0) != 0) ? MODE_STEP : MODE_STOP;
      tick();
      step_press = 1'b0;
    end
    if (len == 0) repeat (3*H) tick();
    drain();
    if (len == 0) check("zero_len_falls", n_falls - f0, 0);
  endtask

  // RUN then STOP: cycles continue through the first rise at or after the stop edge
  task automatic do_run(input int unsigned d);
    int unsigned a, s, k;
    a = cyc + 1;
    s = a + 1 + d;
    k = 0;
    while (a + 1 + H + 2*H*k < s) k++;
    push_cycles(a + 1 + H, k + 1);
    mode = MODE_RUN;
    tick();
    repeat (d) tick();
    mode = MODE_STOP;
    drain();
  endtask

  task automatic do_reset(input bit with_press);
    int unsigned a;
    rst_req = 1'b1;
    if (with_press) begin mode = MODE_STEP; step_press = 1'b1; end
    a = cyc + 1;
    push_reset(a + 1 + H);
    tick();
    rst_req = 1'b0; step_press = 1'b0;
    check("reset_entry_rstn", 32'(mpu_rst_n), 0);
    check("reset_entry_busy", 32'(busy), 1);
    drain();
  endtask

  // Reset request inside the low phase of the second burst cycle
  task automatic do_rst_in_burst(input int unsigned len, input int unsigned off);
    int unsigned a, r1, r;
    mode = MODE_BURST; burst_len = CW'(len); step_press = 1'b1; a = cyc + 1;
    r1 = a + 1 + 3*H;
    r  = r1 - off;
    push_cycles(a + 1 + H, 2);
    sb[sb.size()-1].rstn = 1'b0;
    push_reset(r1 + 2*H);
    tick();
    step_press = 1'b0;
    repeat (r - 1 - a) tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    drain();
  endtask

  initial begin
    int unsigned e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mpu_clk", 32'(mpu_clk), 1);
    check("rst_mpu_rst_n", 32'(mpu_rst_n), 0);
    check("rst_phi_fall", 32'(phi_fall), 0);
    check("rst_phi_rise", 32'(phi_rise), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_cycle_cnt", 32'(cycle_cnt), 0);

    rst_n = 1'b1;
    e = cyc + 1;
    push_reset(e + H);
    tick();
    drain();

    do_step();
    do_burst(5, 1'b1, 1'b0);
    do_burst(0, 1'b0, 1'b0);
    do_run(2);
    do_rst_in_burst(5, 1);
    do_reset(1'b1);
    do_burst(255, 1'b0, 1'b0);
    do_step();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(5, 0))
        0:       do_step();
        1, 2:    do_burst($urandom_range(6, 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        3:       do_run($urandom_range(5*H, 0));
        4:       do_reset(1'($urandom_range(1, 0)));
        default: do_rst_in_burst($urandom_range(6, 3), $urandom_range(H - 1, 0));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
